// File: rtl/div_detect_pkg.sv
// -----------------------------------------------------------------------------
// div_detect_pkg
// Shared definitions for the div_detect block:
//   state_e : FSM state encoding (IDLE, RUN, DONE)
//   clog2   : ceiling log2 used to size the remainder and bit-counter fields
// -----------------------------------------------------------------------------
package div_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest n with 2**n >= value. The 64-bit shift keeps the comparison
  // correct for the full 32-bit operand range.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/div_detect_mod.sv
// -----------------------------------------------------------------------------
// mod_step
// Purely combinational remainder update for MSB-first division by a constant:
//   r_next = (2*r + bit) mod DIVISOR
// Ports:
//   r_i      in  clog2(DIVISOR)  current remainder (always < DIVISOR)
//   bit_i    in  1               next operand bit
//   r_next_o out clog2(DIVISOR)  updated remainder
// -----------------------------------------------------------------------------
module mod_step
  import div_detect_pkg::*;
#(
  parameter int DIVISOR = 10
) (
  input  logic [clog2(DIVISOR)-1:0] r_i,
  input  logic                      bit_i,
  output logic [clog2(DIVISOR)-1:0] r_next_o
);

  localparam int REM_W = clog2(DIVISOR);
  localparam int EXT_W = REM_W + 1;
  localparam logic [EXT_W-1:0] DIV_C = EXT_W'(DIVISOR);

  // 2*r + bit needs one extra bit; since r < DIVISOR the sum is below
  // 2*DIVISOR, so a single conditional subtraction completes the reduction.
  logic [EXT_W-1:0] dbl_s;
  logic [REM_W-1:0] red_s;

  // Widen, then reduce once modulo DIVISOR.
  always_comb begin
    dbl_s = {r_i, bit_i};
    if (dbl_s >= DIV_C) begin
      red_s = REM_W'(dbl_s - DIV_C);
    end else begin
      red_s = REM_W'(dbl_s);
    end
  end

  assign r_next_o = red_s;

endmodule

// File: rtl/div_detect.sv
// -----------------------------------------------------------------------------
// div_detect
// Serial divisibility test of an unsigned operand by a constant DIVISOR.
// One operand bit is consumed per clock, MSB first; the result appears
// WIDTH edges after start is accepted.
// Ports:
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        evaluate A (accepted only while busy = 0)
//   A      in   WIDTH    operand, sampled on the accepting edge only
//   busy   out  1        evaluation in progress
//   done   out  1        one-cycle completion pulse
//   P      out  1        1 = A divisible by DIVISOR; held until next start
//   rem    out  REM_W    A mod DIVISOR; held with P
// -----------------------------------------------------------------------------
module div_detect
  import div_detect_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int DIVISOR = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH-1:0]          A,
  output logic                      busy,
  output logic                      done,
  output logic                      P,
  output logic [clog2(DIVISOR)-1:0] rem
);

  localparam int REM_W = clog2(DIVISOR);
  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [REM_W-1:0]   r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               p_q, p_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [REM_W-1:0]   r_next_s;

  mod_step #(
    .DIVISOR (DIVISOR)
  ) u_step (
    .r_i      (r_q),
    .bit_i    (sh_q[WIDTH-1]),
    .r_next_o (r_next_s)
  );

  // Next-state logic: accept in IDLE/DONE, shift one bit per edge in RUN.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          sh_d    = A;
          r_d     = {REM_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b1;
          p_d     = 1'b0;
          rem_d   = {REM_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: a request during an
        // evaluation is dropped rather than queued.
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        r_d   = r_next_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          p_d     = (r_next_s == {REM_W{1'b0}});
          rem_d   = r_next_s;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= {WIDTH{1'b0}};
      r_q     <= {REM_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= 1'b0;
      rem_q   <= {REM_W{1'b0}};
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;
  assign rem  = rem_q;

endmodule
